// File: rtl/bitcoin_hash_parallelism.sv
// Double SHA-256 nonce search: one shared first-block compression, then NUM_NONCES parallel cores.
// Build option BITCOIN_HASH_DONE_PULSE_EN turns done into a one-cycle pulse instead of a held level.
module bitcoin_hash_parallelism #(
    parameter int NUM_NONCES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] message_addr,
    input  logic [15:0] output_addr,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic [2:0]  dbg_state_o
);
    localparam int NW = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_BLOCK1, S_BLOCK2, S_HASH2, S_WRITE, S_DONE
    } state_t;

    typedef logic [7:0][31:0]  hvec_t;   // [0] = a/H0 ... [7] = h/H7
    typedef logic [15:0][31:0] wvec_t;   // [0] = W[t] of the current round

    localparam hvec_t IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                            32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic hvec_t sha_round(input hvec_t s, input logic [31:0] k, input logic [31:0] wt);
        logic [31:0] t1, t2;
        hvec_t r;
        t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25))
           + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + wt;
        t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22))
           + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
        r = {s[6], s[5], s[4], s[3] + t1, s[2], s[1], s[0], t1 + t2};
        return r;
    endfunction

    function automatic logic [31:0] sched(input wvec_t w);
        return w[0] + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[9]
             + (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10));
    endfunction

    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [15:0] msg_base_q, out_base_q;
    logic [31:0] w_q [19];
    logic [31:0] res_q [NUM_NONCES];
    hvec_t       hs_q [NUM_NONCES];
    hvec_t       hinit_q [NUM_NONCES];
    wvec_t       win_q [NUM_NONCES];
    hvec_t       rnd [NUM_NONCES];
    hvec_t       fin [NUM_NONCES];
    wvec_t       wnext [NUM_NONCES];
    logic [4:0]  rd_idx;
    logic        round_last;

    assign mem_clk        = clk;
    assign done           = done_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_wdata_q;
    assign dbg_state_o    = state_q;
    assign rd_idx         = cnt_q[4:0] - 5'd1;
    assign round_last     = (cnt_q == 7'd63);

    always_comb begin
        for (int n = 0; n < NUM_NONCES; n++) begin
            rnd[n]   = sha_round(hs_q[n], K[cnt_q[5:0]], win_q[n][0]);
            wnext[n] = {sched(win_q[n]), win_q[n][15:1]};
            for (int i = 0; i < 8; i++) fin[n][i] = hinit_q[n][i] + rnd[n][i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d    = S_READ;
                cnt_d      = '0;
                mem_addr_d = message_addr;
                done_d     = 1'b0;
            end
            // Address k is on the bus in READ cycle k; its data is captured at the end of cycle k+1.
            S_READ: begin
                cnt_d = cnt_q + 7'd1;
                if (cnt_q < 7'd18) mem_addr_d = msg_base_q + 16'(cnt_q) + 16'd1;
                if (cnt_q == 7'd19) begin
                    state_d    = S_BLOCK1;
                    cnt_d      = '0;
                    mem_addr_d = '0;
                end
            end
            S_BLOCK1, S_BLOCK2, S_HASH2: begin
                cnt_d = cnt_q + 7'd1;
                if (round_last) begin
                    cnt_d   = '0;
                    state_d = (state_q == S_BLOCK1) ? S_BLOCK2 :
                              (state_q == S_BLOCK2) ? S_HASH2 : S_WRITE;
                end
            end
            S_WRITE: begin
                if (cnt_q < 7'(NUM_NONCES)) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = out_base_q + 16'(cnt_q);
                    mem_wdata_d = res_q[cnt_q[NW-1:0]];
                    cnt_d       = cnt_q + 7'd1;
                end else begin
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    done_d      = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
`ifdef BITCOIN_HASH_DONE_PULSE_EN
                done_d  = 1'b0;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Every phase reuses the same cores; BLOCK1 runs them all on identical data and core 0 supplies the midstate.
    always_ff @(posedge clk) begin
        case (state_q)
            S_IDLE: if (start) begin
                msg_base_q <= message_addr;
                out_base_q <= output_addr;
            end
            S_READ: begin
                if (cnt_q != 7'd0) w_q[rd_idx] <= mem_read_data;
                if (cnt_q == 7'd19) begin
                    for (int n = 0; n < NUM_NONCES; n++) begin
                        hs_q[n]    <= IV;
                        hinit_q[n] <= IV;
                        for (int i = 0; i < 16; i++) win_q[n][i] <= w_q[i];
                    end
                end
            end
            S_BLOCK1, S_BLOCK2, S_HASH2: begin
                for (int n = 0; n < NUM_NONCES; n++) begin
                    if (!round_last) begin
                        hs_q[n]  <= rnd[n];
                        win_q[n] <= wnext[n];
                    end else if (state_q == S_BLOCK1) begin
                        hs_q[n]    <= fin[0];
                        hinit_q[n] <= fin[0];
                        win_q[n]   <= {32'h00000280, 320'h0, 32'h80000000, 32'(n), w_q[18], w_q[17], w_q[16]};
                    end else if (state_q == S_BLOCK2) begin
                        hs_q[n]    <= IV;
                        hinit_q[n] <= IV;
                        win_q[n]   <= {32'h00000100, 192'h0, 32'h80000000, fin[n]};
                    end else begin
                        res_q[n] <= fin[n][0];
                    end
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_bitcoin_hash_parallelism.sv
// Bench for bitcoin_hash_parallelism: memory model, plain double-SHA256 reference, write scoreboard.
module tb_bitcoin_hash_parallelism;
    localparam int NN = 16;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [15:0] message_addr, output_addr;
    logic        done, mem_clk, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data, rd_data;
    logic [2:0]  dbg_state;

    bitcoin_hash_parallelism #(.NUM_NONCES(NN)) dut (
        .clk(clk), .reset(reset), .start(start),
        .message_addr(message_addr), .output_addr(output_addr),
        .done(done), .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(rd_data),
        .dbg_state_o(dbg_state));

    always #5 clk = ~clk;

    logic [31:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_write_data;
        rd_data <= mem[mem_addr];
    end

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int rd_viol = 0;
    logic [15:0] rd_lo = 16'd0;
    logic [47:0] exp_q [$];
    logic [47:0] mon_e;
    logic [18:0][31:0] hdr_cur;
    logic [31:0] gold_exp [NN];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [7:0][31:0] IVT = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [7:0][31:0] compress(input logic [7:0][31:0] hin, input logic [15:0][31:0] m);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        logic [7:0][31:0] r;
        for (int t = 0; t < 16; t++) w[t] = m[t];
        for (int t = 16; t < 64; t++)
            w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        a = hin[0]; b = hin[1]; c = hin[2]; d = hin[3];
        e = hin[4]; f = hin[5]; g = hin[6]; h = hin[7];
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
            t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        r[0] = hin[0] + a; r[1] = hin[1] + b; r[2] = hin[2] + c; r[3] = hin[3] + d;
        r[4] = hin[4] + e; r[5] = hin[5] + f; r[6] = hin[6] + g; r[7] = hin[7] + h;
        return r;
    endfunction

    function automatic logic [31:0] model_h0(input logic [18:0][31:0] hdr, input logic [31:0] nonce);
        logic [15:0][31:0] blk;
        logic [7:0][31:0] mid, d1, d2;
        for (int i = 0; i < 16; i++) blk[i] = hdr[i];
        mid = compress(IVT, blk);
        blk = '0;
        blk[0] = hdr[16]; blk[1] = hdr[17]; blk[2] = hdr[18]; blk[3] = nonce;
        blk[4] = 32'h80000000; blk[15] = 32'd640;
        d1 = compress(mid, blk);
        blk = '0;
        for (int i = 0; i < 8; i++) blk[i] = d1[i];
        blk[8] = 32'h80000000; blk[15] = 32'd256;
        d2 = compress(IVT, blk);
        return d2[0];
    endfunction

    // ---------------- write scoreboard / read monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                wr_cnt++;
                check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(mon_e[47:32]));
                    check("wr_data", mem_write_data, mon_e[31:0]);
                end
            end else if (mem_addr != 16'd0 && (mem_addr < rd_lo || 32'(mem_addr) > 32'(rd_lo) + 18)) begin
                rd_viol++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_header(input logic [31:0] seed, input bit rnd, input logic [15:0] base);
        hdr_cur[0] = seed;
        for (int m = 1; m < 19; m++)
            hdr_cur[m] = rnd ? $urandom : {hdr_cur[m-1][30:0], hdr_cur[m-1][31]};
        for (int m = 0; m < 19; m++) mem[16'(base + m)] <= hdr_cur[m];
        rd_lo = base;
    endtask

    task automatic push_expected(input logic [15:0] out);
        for (int n = 0; n < NN; n++) exp_q.push_back({16'(out + n), model_h0(hdr_cur, 32'(n))});
    endtask

    task automatic start_job(input logic [15:0] msg, input logic [15:0] out, input int ncyc);
        @(posedge clk); #1;
        message_addr = msg;
        output_addr  = out;
        start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("done_low_after_start", 32'(done), 32'd0);
        repeat (ncyc - 1) @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] st);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (dbg_state == st) break;
        end
        check("reach_state", 32'(dbg_state), 32'(st));
    endtask

    task automatic wait_done();
        int lat;
        lat = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
        check("done_seen", 32'(done), 32'd1);
        check("latency_below_300", 32'(lat < 300), 32'd1);
    endtask

    task automatic finish_job(input logic [15:0] msg, input logic [15:0] out, input int wr_before);
        check("wr_count", 32'(wr_cnt - wr_before), 32'(NN));
        check("wr_all_seen", 32'(exp_q.size()), 32'd0);
        check("read_range", 32'(rd_viol), 32'd0);
        for (int n = 0; n < NN; n++) check("mem_result", mem[16'(out + n)], model_h0(hdr_cur, 32'(n)));
        for (int m = 0; m < 19; m++) check("header_intact", mem[16'(msg + m)], hdr_cur[m]);
        @(negedge clk);
`ifdef BITCOIN_HASH_DONE_PULSE_EN
        check("done_pulse_drop", 32'(done), 32'd0);
`else
        check("done_held", 32'(done), 32'd1);
`endif
    endtask

    task automatic full_job(input logic [31:0] seed, input bit rnd, input logic [15:0] msg,
                            input logic [15:0] out, input int ncyc);
        int w0;
        load_header(seed, rnd, msg);
        push_expected(out);
        w0 = wr_cnt;
        start_job(msg, out, ncyc);
        wait_done();
        finish_job(msg, out, w0);
    endtask

    // ---------------- sequence ----------------
    initial begin
        int w0;
        logic [15:0] msg, out;
        reset = 1'b1; start = 1'b0; message_addr = '0; output_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_done", 32'(done), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_write_data, 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        reset = 1'b0;

        // golden run, start held two cycles
        full_job(32'h01234675, 1'b0, 16'd1000, 16'd2000, 2);
        for (int n = 0; n < NN; n++) gold_exp[n] = model_h0(hdr_cur, 32'(n));

        // back-to-back with a new seed and output area
        full_job(32'h00000000, 1'b0, 16'd1000, 16'd3000, 1);
        for (int n = 0; n < NN; n++) check("gold_unchanged", mem[16'(2000 + n)], gold_exp[n]);

        // start pulsed while busy in HASH2
        msg = 16'($urandom_range(4000, 8000));
        out = 16'($urandom_range(9000, 12000));
        load_header($urandom, 1'b1, msg);
        push_expected(out);
        w0 = wr_cnt;
        start_job(msg, out, 1);
        wait_state(3'd4);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done();
        finish_job(msg, out, w0);

        // reset in the middle of BLOCK2
        msg = 16'($urandom_range(20000, 30000));
        load_header($urandom, 1'b1, msg);
        w0 = wr_cnt;
        start_job(msg, 16'd13000, 1);
        wait_state(3'd3);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (300) @(negedge clk);
        check("rst_mid_no_writes", 32'(wr_cnt - w0), 32'd0);
        check("rst_mid_state", 32'(dbg_state), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        full_job(hdr_cur[0], 1'b0, msg, 16'd13000, 1);

        // random headers and addresses
        for (int j = 0; j < 2; j++) begin
            msg = 16'($urandom_range(31000, 40000));
            out = 16'($urandom_range(41000, 60000));
            full_job($urandom, 1'b1, msg, out, $urandom_range(1, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
